// File: rtl/cpu_pkg.sv
// Shared definitions for the phase-1 hardwired control sequencer:
// opcodes, state encodings, IR field positions and the strobe bundle.
package cpu_pkg;

  localparam int OPW    = 5;
  localparam int REGW   = 4;
  localparam int OP_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;

  localparam logic [OPW-1:0] OP_ADD = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB = 5'b00100;
  localparam logic [OPW-1:0] OP_SHR = 5'b00101;
  localparam logic [OPW-1:0] OP_SHL = 5'b00110;
  localparam logic [OPW-1:0] OP_ROR = 5'b00111;
  localparam logic [OPW-1:0] OP_ROL = 5'b01000;
  localparam logic [OPW-1:0] OP_AND = 5'b01001;
  localparam logic [OPW-1:0] OP_OR  = 5'b01010;
  localparam logic [OPW-1:0] OP_NOP = 5'b11000;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_HALT = 4'd7
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic mdr_out;
    logic r_out;
    logic mar_in;
    logic z_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic r_in;
    logic inc_pc;
    logic read;
    logic gra;
    logic grb;
    logic grc;
    logic done;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/seq_decode.sv
// Opcode classifier for the control sequencer.
// Flags supported ALU ops and NOP; ALU op is zero for anything else.
module seq_decode
  import cpu_pkg::*;
(
  input  logic [OPW-1:0] op,
  output logic           supported,
  output logic           nop,
  output logic [OPW-1:0] alu_op
);

  always_comb begin
    supported = 1'b0;
    nop       = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR: supported = 1'b1;
      OP_NOP:                        nop = 1'b1;
      default: ;
    endcase
    alu_op = supported ? op : '0;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for three-register ALU instructions.
// Moore strobes decoded from the state register, all gated off while frozen.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           Run,
  input  logic           Stop,
  input  logic [31:0]    IR,
  output logic           PCout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           Rout,
  output logic           MARin,
  output logic           Zin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           Rin,
  output logic           IncPC,
  output logic           Read,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic [OPW-1:0] ALUop,
  output logic           Done,
  output logic           Halted,
  output logic           Illegal,
  output logic [3:0]     State
);

  state_t         state;
  logic           stop_pend;
  logic           supported;
  logic           nop;
  logic [OPW-1:0] dec_alu;
  logic [OPW-1:0] alu;
  ctrl_t          c;
  logic           unused_ir;

  assign unused_ir = ^IR[OP_LSB-1:0];

  seq_decode u_dec (
    .op        (IR[OP_LSB +: OPW]),
    .supported (supported),
    .nop       (nop),
    .alu_op    (dec_alu)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= ST_RST;
      stop_pend <= 1'b0;
    end else begin
      if (state == ST_RST || state == ST_HALT)
        stop_pend <= 1'b0;
      else if (Stop)
        stop_pend <= 1'b1;
      if (Run) begin
        unique case (state)
          ST_RST:  state <= ST_T0;
          ST_T0:   state <= ST_T1;
          ST_T1:   state <= ST_T2;
          ST_T2:   state <= ST_T3;
          ST_T3:   state <= supported ? ST_T4 : ST_T0;
          ST_T4:   state <= ST_T5;
          // a stop arriving in T5 itself still halts here
          ST_T5:   state <= (stop_pend || Stop) ? ST_HALT : ST_T0;
          ST_HALT: state <= ST_HALT;
          default: state <= ST_RST;
        endcase
      end
    end
  end

  always_comb begin
    c   = '0;
    alu = '0;
    if (Run) begin
      unique case (state)
        ST_T0: begin
          c.pc_out = 1'b1;
          c.mar_in = 1'b1;
          c.inc_pc = 1'b1;
          c.z_in   = 1'b1;
        end
        ST_T1: begin
          c.zlow_out = 1'b1;
          c.pc_in    = 1'b1;
          c.read     = 1'b1;
          c.mdr_in   = 1'b1;
        end
        ST_T2: begin
          c.mdr_out = 1'b1;
          c.ir_in   = 1'b1;
        end
        ST_T3: begin
          if (supported) begin
            c.grb   = 1'b1;
            c.r_out = 1'b1;
            c.y_in  = 1'b1;
          end else if (!nop) begin
            c.illegal = 1'b1;
          end
        end
        ST_T4: begin
          c.grc   = 1'b1;
          c.r_out = 1'b1;
          c.z_in  = 1'b1;
          alu     = dec_alu;
        end
        ST_T5: begin
          c.zlow_out = 1'b1;
          c.gra      = 1'b1;
          c.r_in     = 1'b1;
          c.done     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign PCout   = c.pc_out;
  assign Zlowout = c.zlow_out;
  assign MDRout  = c.mdr_out;
  assign Rout    = c.r_out;
  assign MARin   = c.mar_in;
  assign Zin     = c.z_in;
  assign PCin    = c.pc_in;
  assign MDRin   = c.mdr_in;
  assign IRin    = c.ir_in;
  assign Yin     = c.y_in;
  assign Rin     = c.r_in;
  assign IncPC   = c.inc_pc;
  assign Read    = c.read;
  assign Gra     = c.gra;
  assign Grb     = c.grb;
  assign Grc     = c.grc;
  assign Done    = c.done;
  assign Illegal = c.illegal;
  assign ALUop   = alu;
  assign Halted  = (state == ST_HALT);
  assign State   = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, ALU sequence, freeze,
// stop/halt, illegal/NOP decode and stop-vs-reset priority.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] ir = 32'h0;

  logic PCout, Zlowout, MDRout, Rout, MARin, Zin, PCin, MDRin, IRin;
  logic Yin, Rin, IncPC, Read, Gra, Grb, Grc, Done, Halted, Illegal;
  logic [4:0] ALUop;
  logic [3:0] State;
  logic [18:0] obs;

  int checks = 0;
  int passed = 0;

  localparam logic [18:0] B_PCOUT   = 19'b1 << 18;
  localparam logic [18:0] B_ZLOWOUT = 19'b1 << 17;
  localparam logic [18:0] B_MDROUT  = 19'b1 << 16;
  localparam logic [18:0] B_ROUT    = 19'b1 << 15;
  localparam logic [18:0] B_MARIN   = 19'b1 << 14;
  localparam logic [18:0] B_ZIN     = 19'b1 << 13;
  localparam logic [18:0] B_PCIN    = 19'b1 << 12;
  localparam logic [18:0] B_MDRIN   = 19'b1 << 11;
  localparam logic [18:0] B_IRIN    = 19'b1 << 10;
  localparam logic [18:0] B_YIN     = 19'b1 << 9;
  localparam logic [18:0] B_RIN     = 19'b1 << 8;
  localparam logic [18:0] B_INCPC   = 19'b1 << 7;
  localparam logic [18:0] B_READ    = 19'b1 << 6;
  localparam logic [18:0] B_GRA     = 19'b1 << 5;
  localparam logic [18:0] B_GRB     = 19'b1 << 4;
  localparam logic [18:0] B_GRC     = 19'b1 << 3;
  localparam logic [18:0] B_DONE    = 19'b1 << 2;
  localparam logic [18:0] B_ILLEGAL = 19'b1 << 1;
  localparam logic [18:0] B_HALTED  = 19'b1;

  localparam logic [18:0] E_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
  localparam logic [18:0] E_T1 = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [18:0] E_T2 = B_MDROUT | B_IRIN;
  localparam logic [18:0] E_T3 = B_GRB | B_ROUT | B_YIN;
  localparam logic [18:0] E_T4 = B_GRC | B_ROUT | B_ZIN;
  localparam logic [18:0] E_T5 = B_ZLOWOUT | B_GRA | B_RIN | B_DONE;

  localparam logic [31:0] IR_AND = 32'h4A920000;
  localparam logic [31:0] IR_BAD = 32'hF8000000;
  localparam logic [31:0] IR_NOP = 32'hC0000000;

  always #5 clk = ~clk;

  assign obs = {PCout, Zlowout, MDRout, Rout, MARin, Zin, PCin, MDRin,
                IRin, Yin, Rin, IncPC, Read, Gra, Grb, Grc, Done,
                Illegal, Halted};

  control_sequencer dut (
    .Clock   (clk),
    .Resetn  (rst_n),
    .Run     (run),
    .Stop    (stop),
    .IR      (ir),
    .PCout   (PCout),
    .Zlowout (Zlowout),
    .MDRout  (MDRout),
    .Rout    (Rout),
    .MARin   (MARin),
    .Zin     (Zin),
    .PCin    (PCin),
    .MDRin   (MDRin),
    .IRin    (IRin),
    .Yin     (Yin),
    .Rin     (Rin),
    .IncPC   (IncPC),
    .Read    (Read),
    .Gra     (Gra),
    .Grb     (Grb),
    .Grc     (Grc),
    .ALUop   (ALUop),
    .Done    (Done),
    .Halted  (Halted),
    .Illegal (Illegal),
    .State   (State)
  );

  // inputs change just after the falling edge; the next rising edge acts on them
  task automatic go(input logic r, input logic s);
    @(negedge clk);
    run  = r;
    stop = s;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ir    = IR_AND;
    go(1'b0, 1'b0);
    checks++;
    if (obs !== 19'h0 || State !== 4'd0 || ALUop !== 5'd0)
      $display("FAIL reset_init: obs=%h st=%0d alu=%b want 0", obs, State, ALUop);
    else passed++;
    rst_n = 1'b1;
    go(1'b1, 1'b0);
    checks++;
    if (State !== 4'd0 || obs !== 19'h0)
      $display("FAIL reset_rst: st=%0d obs=%h want st=0 obs=0", State, obs);
    else passed++;
    go(1'b1, 1'b0);
    checks++;
    if (State !== 4'd1)
      $display("FAIL reset_t0: st=%0d want 1", State);
    else passed++;
    repeat (4) go(1'b1, 1'b0);
    checks++;
    if (State !== 4'd5 || ALUop !== 5'b01001)
      $display("FAIL reach_t4: st=%0d alu=%b want 5/01001", State, ALUop);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 19'h0 || State !== 4'd0 || ALUop !== 5'd0)
      $display("FAIL reset_mid: obs=%h st=%0d alu=%b want 0", obs, State, ALUop);
    else passed++;
    go(1'b1, 1'b0);
    checks++;
    if (obs !== 19'h0 || State !== 4'd0)
      $display("FAIL reset_hold: obs=%h st=%0d want 0", obs, State);
    else passed++;
    rst_n = 1'b1;
    #1;
    checks++;
    if (State !== 4'd0)
      $display("FAIL reset_rel: st=%0d want 0", State);
    else passed++;
    go(1'b1, 1'b0);
    checks++;
    if (State !== 4'd1 || obs !== E_T0)
      $display("FAIL reset_to_t0: st=%0d obs=%h want 1/%h", State, obs, E_T0);
    else passed++;
  endtask

  task automatic test_alu;
    logic [3:0]  est [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1};
    logic [18:0] eob [7] = '{E_T0, E_T1, E_T2, E_T3, E_T4, E_T5, E_T0};
    logic [4:0]  eal [7] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b01001, 5'd0, 5'd0};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) go(1'b1, 1'b0);
      checks++;
      if (State !== est[i] || obs !== eob[i] || ALUop !== eal[i])
        $display("FAIL alu_step[%0d]: st=%0d obs=%h alu=%b want %0d/%h/%b",
                 i, State, obs, ALUop, est[i], eob[i], eal[i]);
      else passed++;
    end
  endtask

  task automatic test_freeze;
    run = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (State !== 4'd1 || IncPC !== 1'b0 || obs !== 19'h0)
        $display("FAIL freeze[%0d]: st=%0d incpc=%b obs=%h want 1/0/0",
                 k, State, IncPC, obs);
      else passed++;
      go(1'b0, 1'b0);
    end
    run = 1'b1;
    #1;
    checks++;
    if (State !== 4'd1 || IncPC !== 1'b1)
      $display("FAIL resume: st=%0d incpc=%b want 1/1", State, IncPC);
    else passed++;
    go(1'b1, 1'b0);
    checks++;
    if (State !== 4'd2 || IncPC !== 1'b0)
      $display("FAIL resume_once: st=%0d incpc=%b want 2/0", State, IncPC);
    else passed++;
  endtask

  task automatic test_stop;
    stop = 1'b1;
    #1;
    go(1'b1, 1'b0);
    checks++;
    if (State !== 4'd3 || Halted !== 1'b0)
      $display("FAIL stop_t2: st=%0d halted=%b want 3/0", State, Halted);
    else passed++;
    repeat (3) go(1'b1, 1'b0);
    checks++;
    if (State !== 4'd6 || obs !== E_T5)
      $display("FAIL stop_t5: st=%0d obs=%h want 6/%h", State, obs, E_T5);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      go(1'b1, 1'b0);
      checks++;
      if (State !== 4'd7 || obs !== B_HALTED)
        $display("FAIL halt[%0d]: st=%0d obs=%h want 7/%h",
                 k, State, obs, B_HALTED);
      else passed++;
    end
  endtask

  task automatic test_illegal;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    ir = IR_BAD;
    go(1'b1, 1'b0);
    repeat (3) go(1'b1, 1'b0);
    checks++;
    if (State !== 4'd4 || obs !== B_ILLEGAL || ALUop !== 5'd0)
      $display("FAIL illegal_t3: st=%0d obs=%h alu=%b want 4/%h/0",
               State, obs, ALUop, B_ILLEGAL);
    else passed++;
    go(1'b1, 1'b0);
    checks++;
    if (State !== 4'd1 || obs !== E_T0)
      $display("FAIL illegal_next: st=%0d obs=%h want 1/%h", State, obs, E_T0);
    else passed++;
    ir = IR_NOP;
    repeat (3) go(1'b1, 1'b0);
    checks++;
    if (State !== 4'd4 || obs !== 19'h0)
      $display("FAIL nop_t3: st=%0d obs=%h want 4/0", State, obs);
    else passed++;
    go(1'b1, 1'b0);
    checks++;
    if (State !== 4'd1 || obs !== E_T0)
      $display("FAIL nop_next: st=%0d obs=%h want 1/%h", State, obs, E_T0);
    else passed++;
  endtask

  task automatic test_stop_reset;
    stop  = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (State !== 4'd0 || obs !== 19'h0)
      $display("FAIL stop_rst: st=%0d obs=%h want 0/0", State, obs);
    else passed++;
    go(1'b1, 1'b0);
    ir    = IR_AND;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 7; i++) begin
      go(1'b1, 1'b0);
      checks++;
      if (State !== ((i == 6) ? 4'd1 : 4'(i + 1)))
        $display("FAIL post_rst[%0d]: st=%0d want %0d",
                 i, State, (i == 6) ? 1 : i + 1);
      else passed++;
    end
    checks++;
    if (Halted !== 1'b0)
      $display("FAIL no_halt: halted=%b want 0", Halted);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_freeze;
    test_stop;
    test_illegal;
    test_stop_reset;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
